modexp_ctrl: RTL and testbench

Sequencer that computes a modular exponentiation by driving a single shared MonPro datapath with left-to-right square-and-multiply. It steps through the Montgomery-domain conversions, the squares and multiplies selected by the exponent bits, and the final conversion back out. It issues one MonPro command at a time and owns no arithmetic. It sits between the RSA top-level command interface and the `monpro` core plus its operand banks.

---
 rtl/modexp_pkg.sv | 32 +++
 rtl/exp_bit_scanner.sv | 86 ++++++++
 rtl/modexp_ctrl.sv | 148 ++++++++++++++
 tb/tb_modexp_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/modexp_pkg.sv
// Shared types and constants for the modular-exponentiation sequencer.
// Bank-select codes match the operand/destination mux of the MonPro banks.
package modexp_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int TOTAL_ADDR_DEF = 128;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CONV_M,
    ST_CONV_A,
    ST_FETCH,
    ST_SQUARE,
    ST_MULT,
    ST_NEXT,
    ST_CONV_OUT,
    ST_DONE
  } state_t;

  localparam logic [2:0] SEL_MSG    = 3'd0;
  localparam logic [2:0] SEL_R2     = 3'd1;
  localparam logic [2:0] SEL_ONE    = 3'd2;
  localparam logic [2:0] SEL_MBAR   = 3'd3;
  localparam logic [2:0] SEL_ABAR   = 3'd4;
  localparam logic [2:0] SEL_RESULT = 3'd5;

  // A one-word exponent memory still needs a 1-bit address port.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exp_bit_scanner.sv
// Exponent bit scanner: word fetch, MSB-first shift register, bit/word counters.
// MODEXP_SKIP_LEADING_ZEROS_EN enables the leading-zero skip flag.
module exp_bit_scanner
  import modexp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TOTAL_ADDR = TOTAL_ADDR_DEF
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                init,
  input  logic                                fetch,
  input  logic                                advance,
  input  logic [DATA_WIDTH-1:0]               exp_rdata,
  output logic [addr_width(TOTAL_ADDR)-1:0]   exp_addr,
  output logic                                cur_bit,
  output logic                                bit_next,
  output logic                                bit_valid,
  output logic                                loading,
  output logic                                word_end,
  output logic                                last,
  output logic                                skip_zero
);

  localparam int AW = addr_width(TOTAL_ADDR);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] shift_q;
  logic [CW-1:0]         cnt_q;
  logic [AW-1:0]         word_q;
  logic                  load_q;

  assign exp_addr  = word_q;
  assign cur_bit   = shift_q[DATA_WIDTH-1];
  assign bit_valid = (cnt_q != '0);
  assign loading   = load_q;
  assign word_end  = (cnt_q == CW'(1));
  assign last      = word_end && (word_q == '0);
  // Bit that becomes current after this cycle's load or shift.
  assign bit_next  = load_q ? exp_rdata[DATA_WIDTH-1] : shift_q[DATA_WIDTH-2];

  // Fetch is two cycles: address out, then latch the synchronous read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      load_q  <= 1'b0;
    end else if (init) begin
      cnt_q   <= '0;
      word_q  <= AW'(TOTAL_ADDR - 1);
      load_q  <= 1'b0;
    end else if (load_q) begin
      shift_q <= exp_rdata;
      cnt_q   <= CW'(DATA_WIDTH);
      load_q  <= 1'b0;
    end else if (fetch) begin
      load_q  <= 1'b1;
    end else if (advance && bit_valid) begin
      shift_q <= shift_q << 1;
      cnt_q   <= cnt_q - CW'(1);
      if (word_end && (word_q != '0)) begin
        word_q <= word_q - AW'(1);
      end
    end
  end

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  logic lead_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lead_q <= 1'b1;
    end else if (init) begin
      lead_q <= 1'b1;
    end else if (bit_valid && cur_bit) begin
      lead_q <= 1'b0;
    end
  end

  assign skip_zero = lead_q;
`else
  assign skip_zero = 1'b0;
`endif

endmodule

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one shared MonPro core.
// Optional leading-zero skip: MODEXP_SKIP_LEADING_ZEROS_EN (handled in exp_bit_scanner).
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TOTAL_ADDR = TOTAL_ADDR_DEF
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic [addr_width(TOTAL_ADDR)-1:0]   exp_addr,
  input  logic [DATA_WIDTH-1:0]               exp_rdata,
  output logic                                mp_start,
  output logic [2:0]                          mp_sel_x,
  output logic [2:0]                          mp_sel_y,
  output logic [2:0]                          mp_sel_dst,
  input  logic                                mp_done,
  output logic [15:0]                         op_count,
  output state_t                              dbg_state
);

  // MonPro handshake: mp_start pulses for one cycle with the selects valid;
  // the selects stay put until mp_done, which is honoured only while issued_q.

  state_t state_q, next_state;
  logic   issued_q, issued_d;
  logic   issuing, issue_done;
  logic   init, fetch, advance;
  logic   cur_bit, bit_next, bit_valid, loading, word_end, last, skip_zero;
  logic [15:0] op_count_q;

  exp_bit_scanner #(
    .DATA_WIDTH (DATA_WIDTH),
    .TOTAL_ADDR (TOTAL_ADDR)
  ) u_scanner (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .fetch     (fetch),
    .advance   (advance),
    .exp_rdata (exp_rdata),
    .exp_addr  (exp_addr),
    .cur_bit   (cur_bit),
    .bit_next  (bit_next),
    .bit_valid (bit_valid),
    .loading   (loading),
    .word_end  (word_end),
    .last      (last),
    .skip_zero (skip_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      issued_q   <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q  <= next_state;
      issued_q <= issued_d;
      if (init) begin
        op_count_q <= '0;
      end else if (mp_start) begin
        op_count_q <= op_count_q + 16'd1;
      end
    end
  end

  assign issuing    = (state_q == ST_CONV_M) || (state_q == ST_CONV_A) ||
                      (state_q == ST_SQUARE) || (state_q == ST_MULT)   ||
                      (state_q == ST_CONV_OUT);
  assign issue_done = issued_q && mp_done;
  assign init       = (state_q == ST_IDLE) && start;
  assign fetch      = (state_q == ST_FETCH);
  assign advance    = (state_q == ST_NEXT);

  assign mp_start   = issuing && !issued_q;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign op_count   = op_count_q;
  assign dbg_state  = state_q;

  always_comb begin
    next_state = state_q;
    issued_d   = 1'b0;
    mp_sel_x   = SEL_MSG;
    mp_sel_y   = SEL_MSG;
    mp_sel_dst = SEL_MSG;
    if (issuing) begin
      issued_d = issued_q ? !mp_done : 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (start) next_state = ST_CONV_M;
      end
      ST_CONV_M: begin
        mp_sel_x   = SEL_MSG;
        mp_sel_y   = SEL_R2;
        mp_sel_dst = SEL_MBAR;
        if (issue_done) next_state = ST_CONV_A;
      end
      ST_CONV_A: begin
        mp_sel_x   = SEL_ONE;
        mp_sel_y   = SEL_R2;
        mp_sel_dst = SEL_ABAR;
        if (issue_done) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        if (loading) next_state = (skip_zero && !bit_next) ? ST_NEXT : ST_SQUARE;
      end
      ST_SQUARE: begin
        mp_sel_x   = SEL_ABAR;
        mp_sel_y   = SEL_ABAR;
        mp_sel_dst = SEL_ABAR;
        if (issue_done) next_state = (bit_valid && cur_bit) ? ST_MULT : ST_NEXT;
      end
      ST_MULT: begin
        mp_sel_x   = SEL_MBAR;
        mp_sel_y   = SEL_ABAR;
        mp_sel_dst = SEL_ABAR;
        if (issue_done) next_state = ST_NEXT;
      end
      ST_NEXT: begin
        // Leading zeros loop here one bit per cycle without issuing.
        if (word_end) begin
          next_state = last ? ST_CONV_OUT : ST_FETCH;
        end else begin
          next_state = (skip_zero && !bit_next) ? ST_NEXT : ST_SQUARE;
        end
      end
      ST_CONV_OUT: begin
        mp_sel_x   = SEL_ABAR;
        mp_sel_y   = SEL_ONE;
        mp_sel_dst = SEL_RESULT;
        if (issue_done) next_state = ST_DONE;
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: MonPro value model over a small modulus, command
// queue built from the square-and-multiply rules, and a plain powmod reference.
module tb_modexp_ctrl;
  import modexp_pkg::*;

  localparam int DW   = 8;
  localparam int TA   = 2;
  localparam int NMOD = 97;  // modulus N
  localparam int RINV = 72;  // R^-1 mod N with R = 128
  localparam int R2V  = 88;  // R^2 mod N
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif
  localparam logic [8:0] C_SQ  = {SEL_ABAR, SEL_ABAR, SEL_ABAR};
  localparam logic [8:0] C_MUL = {SEL_MBAR, SEL_ABAR, SEL_ABAR};
  localparam logic [8:0] C_OUT = {SEL_ABAR, SEL_ONE, SEL_RESULT};

  logic          clk = 1'b0;
  logic          reset, start, mp_done;
  logic          busy, done, mp_start;
  logic [0:0]    exp_addr;
  logic [DW-1:0] exp_rdata;
  logic [2:0]    mp_sel_x, mp_sel_y, mp_sel_dst;
  logic [15:0]   op_count;
  state_t        dbg_state;

  logic [DW-1:0] mem [TA];
  logic [8:0]    exp_q[$];
  logic [8:0]    cmd_log[$];
  logic [8:0]    saved_log[$];
  int            bank[8];
  int            tests = 0, fails = 0;
  int            lat_cfg = 5, n_issued = 0, cyc_cnt = 0, last_done_cyc = 0, spur_req = 0;

  modexp_ctrl #(.DATA_WIDTH(DW), .TOTAL_ADDR(TA)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .exp_addr(exp_addr), .exp_rdata(exp_rdata), .mp_start(mp_start),
    .mp_sel_x(mp_sel_x), .mp_sel_y(mp_sel_y), .mp_sel_dst(mp_sel_dst),
    .mp_done(mp_done), .op_count(op_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;
  always @(posedge clk) exp_rdata <= mem[exp_addr];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  function automatic int mp(input int x, input int y);
    return (x * y * RINV) % NMOD;
  endfunction

  function automatic int powmod(input int m, input logic [15:0] e);
    int r = 1;
    int b = m % NMOD;
    for (int i = 0; i < 16; i++) begin
      if (e[i]) r = (r * b) % NMOD;
      b = (b * b) % NMOD;
    end
    return r;
  endfunction

  function automatic int ops_formula(input logic [15:0] e);
    int span = 16;
    if (SKIP_EN) begin
      span = 0;
      for (int i = 0; i < 16; i++) if (e[i]) span = i + 1;
    end
    return 3 + span + $countones(e);
  endfunction

  task automatic build_model(input logic [15:0] e);
    bit seen = 1'b0;
    exp_q.delete();
    exp_q.push_back({SEL_MSG, SEL_R2, SEL_MBAR});
    exp_q.push_back({SEL_ONE, SEL_R2, SEL_ABAR});
    for (int i = 15; i >= 0; i--) begin
      if (SKIP_EN && !seen && !e[i]) continue;
      seen = 1'b1;
      exp_q.push_back(C_SQ);
      if (e[i]) exp_q.push_back(C_MUL);
    end
    exp_q.push_back(C_OUT);
  endtask

  // MonPro model and per-cycle compare process.
  initial begin : mp_model
    int cnt;
    logic [8:0] cur, got;
    cnt = 0;
    cur = '0;
    mp_done = 1'b0;
    forever begin
      @(negedge clk);
      mp_done = 1'b0;
      if (spur_req != 0) begin
        mp_done = 1'b1;
        spur_req = 0;
      end
      if (reset) begin
        cnt = 0;
      end else begin
        if (busy) check("op_count_live", op_count, n_issued);
        if (cnt > 0) begin
          check("sel_stable", {mp_sel_x, mp_sel_y, mp_sel_dst}, cur);
          cnt--;
          if (cnt == 0) begin
            bank[cur[2:0]] = mp(bank[cur[8:6]], bank[cur[5:3]]);
            mp_done = 1'b1;
            last_done_cyc = cyc_cnt;
          end
        end
        if (mp_start) begin
          got = {mp_sel_x, mp_sel_y, mp_sel_dst};
          cmd_log.push_back(got);
          if (cnt > 0) fail_now("overlapping_mp_start");
          if (exp_q.size() == 0) fail_now("extra_command");
          else check("cmd", got, exp_q.pop_front());
          n_issued++;
          cur = got;
          cnt = lat_cfg;
        end
      end
    end
  end

  task automatic launch(input logic [15:0] e, input int msg, input int lat);
    mem[1] = e[15:8];
    mem[0] = e[7:0];
    lat_cfg = lat;
    bank = '{default: 0};
    bank[SEL_MSG] = msg;
    bank[SEL_R2] = R2V;
    bank[SEL_ONE] = 1;
    build_model(e);
    cmd_log.delete();
    n_issued = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_t1", busy, 1);
    check("mp_start_t1", mp_start, 1);
  endtask

  task automatic run_exp(input logic [15:0] e, input int msg, input int lat, input bit poke);
    bit got_done = 1'b0;
    launch(e, msg, lat);
    for (int c = 0; c < 20000 && !got_done; c++) begin
      @(negedge clk);
      start = (poke && busy && (c % 37 == 30)) ? 1'b1 : 1'b0;
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    if (!got_done) begin
      fail_now("done_timeout");
      return;
    end
    check("done_latency", cyc_cnt - last_done_cyc, 1);
    check("busy_at_done", busy, 0);
    check("op_count_done", op_count, ops_formula(e));
    check("queue_empty", exp_q.size(), 0);
    check("result", bank[SEL_RESULT], powmod(msg, e));
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mp_start"}, mp_start, 0);
    check({tag, "_sels"}, {mp_sel_x, mp_sel_y, mp_sel_dst}, 0);
    check({tag, "_exp_addr"}, exp_addr, 0);
    check({tag, "_op_count"}, op_count, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int saved_ops;
    bit same;
    reset = 1'b1;
    start = 1'b0;
    mem[0] = '0;
    mem[1] = '0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;

    // e = 3, msg = 2: 2^3 mod 97 = 8; tail SQ, MUL, SQ, MUL, OUT.
    run_exp(16'h0003, 2, 5, 1'b0);
    check("e3_ops_literal", op_count, SKIP_EN ? 7 : 21);
    check("e3_result_literal", bank[SEL_RESULT], 8);
    check("e3_log_len", cmd_log.size(), SKIP_EN ? 7 : 21);
    if (cmd_log.size() >= 5) begin
      check("tail_sq0", cmd_log[cmd_log.size()-5], C_SQ);
      check("tail_mul0", cmd_log[cmd_log.size()-4], C_MUL);
      check("tail_sq1", cmd_log[cmd_log.size()-3], C_SQ);
      check("tail_mul1", cmd_log[cmd_log.size()-2], C_MUL);
      check("tail_out", cmd_log[cmd_log.size()-1], C_OUT);
    end
    saved_log = cmd_log;

    // Same exponent with back-to-back completions.
    run_exp(16'h0003, 2, 1, 1'b0);
    same = (cmd_log.size() == saved_log.size());
    for (int i = 0; i < cmd_log.size() && same; i++) same = (cmd_log[i] == saved_log[i]);
    check("lat1_same_sequence", same, 1);

    // All-zero exponent: result is 1.
    run_exp(16'h0000, 5, 3, 1'b0);
    check("e0_result_literal", bank[SEL_RESULT], 1);
    check("e0_ops_literal", op_count, SKIP_EN ? 3 : 19);

    // Spurious mp_done while idle.
    saved_ops = op_count;
    spur_req = 1;
    repeat (4) @(negedge clk);
    check("spur_op_count", op_count, saved_ops);
    check("spur_state", dbg_state, ST_IDLE);

    // Random exponents, messages and latencies, with start re-pulsed mid-run.
    for (int k = 0; k < 4; k++) begin
      run_exp(16'($urandom_range(0, 65535)), $urandom_range(1, NMOD - 1),
              $urandom_range(1, 6), 1'b1);
    end
    run_exp(16'h8001, 3, 2, 1'b1);

    // Reset while waiting on the 10th completion, then a clean re-run.
    launch(16'hFFFF, 7, 5);
    for (int k = 0; k < 2000 && n_issued < 10; k++) @(negedge clk);
    check("pre_reset_issued", n_issued, 10);
    #2 reset = 1'b1;
    #1 check_reset_values("midrst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    run_exp(16'h00A5, 11, 2, 1'b0);
    check("rerun_first_cmd", cmd_log.size() > 0 ? int'(cmd_log[0]) : -1,
          {SEL_MSG, SEL_R2, SEL_MBAR});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
